prbs31_checker: RTL
===================

Name: prbs31_checker

Overview:
- Serial PRBS31 (x^31 + x^28 + 1) checker. It sits directly downstream of the PRBS31 generator / stochastic bitstream tile.
- Consumes one bit per enabled cycle and self-synchronises to the incoming sequence.
- Declares lock, then counts bit errors against a free-running local replica.
- Tracks loss of lock, so bench or silicon can measure the BER of the generator output path.

Parameters:
- CNT_W, 16, width of the saturating error and bit counters.
- LOCK_BITS, 64, consecutive correct predictions required to declare lock.
- WIN_LOG2, 7, log2 of the loss-of-lock observation window in valid bits (128).
- LOSS_THR, 16, errors within one window that force loss of lock.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, bit_in is valid this cycle; nothing advances when low.
- bit_in, input, 1, received serial PRBS bit.
- clear, input, 1, synchronous clear of err_count and bit_count only.
- locked, output, 1, checker is in LOCKED state.
- err_pulse, output, 1, one-cycle pulse per detected error.
- err_count, output, CNT_W, saturating error count, LOCKED state only.
- bit_count, output, CNT_W, saturating count of bits checked while LOCKED.

Behaviour:
- Reset (rst_n low at an edge): state=SEED; shift reg s[30:0]=0; seed/verify/window counters=0; locked=0; err_pulse=0; err_count=0; bit_count=0. This overrides any operation in progress, including mid-lock.
- Prediction: pred = s[30] ^ s[27]. The shift always moves s[30:1]<=s[29:0] and loads the new bit into s[0]. This uses the same tap convention as the generator.
- SEED:
  - Each en cycle shifts bit_in into s.
  - After 31 valid bits, go to VERIFY, unless s (including the bit shifted in that cycle) is all-zero. In that case restart the seed count and stay in SEED, because the all-zero state is degenerate.
- VERIFY:
  - Each en cycle compares bit_in against pred, then shifts bit_in.
  - Any mismatch: go to SEED with the seed count cleared; err_count is not touched.
  - LOCK_BITS consecutive matches: go to LOCKED.
  - locked rises on the edge that processes the final matching bit. With continuous en, locked is high in the cycle after the 95th valid bit.
- LOCKED:
  - Each en cycle shifts pred, not bit_in (local generator, so no error multiplication).
  - err = bit_in != pred.
  - err_pulse is registered: it is high in the cycle after the erroneous bit, for exactly one cycle.
  - bit_count increments per en cycle; err_count increments per err. Both saturate at 2^CNT_W-1 and do not wrap.
  - Window logic: a window counter counts en cycles, with an error tally beside it.
    - When the tally reaches LOSS_THR: go to SEED, locked falls on that edge, and the window counter and tally clear.
    - When the window counter wraps at 2^WIN_LOG2 without reaching LOSS_THR: clear the tally.
- en=0: no state, counter or shift change; err_pulse=0.
- clear:
  - Zeroes err_count and bit_count on that edge and wins over a coincident increment (result 0).
  - Does not affect state, lock or window tally.
- err_count and bit_count hold their values across loss of lock; only clear or reset zero them.
- err_pulse is never asserted outside LOCKED.

Decomposition:
- Package prbs_pkg: tap constants (PRBS31_LEN=31, PRBS31_TAP=27), state enum {SEED, VERIFY, LOCKED}, and a next-bit function.
- Sub-module prbs31_next: a combinational next-bit function of a 31-bit state. It is shared with the generator so both sides use identical taps.
- FSM, counters and window logic stay in prbs31_checker.

Test Plan:
- Reset, then a continuous PRBS31 stream from generator seed 31'd1 with en=1 -> locked=1 in the cycle after valid bit 95; err_count=0. After a further 1000 bits: bit_count=1000, err_pulse never high.
- After lock, flip one bit -> err_pulse high exactly one cycle, in the cycle after the flipped bit; err_count=1; locked stays 1; following bits produce no further errors.
- 300 bits of constant 0 -> locked never 1; state remains SEED; err_count=0.
- After lock, drive random bits (about 50% errors) -> locked drops on the edge of the 16th error within the window; err_count retains its value. Return to the clean stream -> relock after 95 further valid bits.
- en toggled 1/0 each cycle with a clean stream -> lock after 95 valid bits (190 cycles); no advance on en=0 cycles.
- clear asserted on the same edge as an error -> err_count=0 and bit_count=0 afterwards. rst_n low one cycle while locked -> locked=0 and all counters 0 after that edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions used by both the generator and the checker.
package prbs_pkg;

    localparam int PRBS31_LEN = 31;
    localparam int PRBS31_TAP = 27;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic prbs31_next_bit(input logic [PRBS31_LEN-1:0] s);
        return s[PRBS31_LEN-1] ^ s[PRBS31_TAP];
    endfunction

endpackage

// File: rtl/prbs31_next.sv
// Combinational PRBS31 next-bit from a 31-bit state; shared with the generator so taps cannot drift.
module prbs31_next
    import prbs_pkg::*;
(
    input  logic [PRBS31_LEN-1:0] i_state,
    output logic                  o_bit
);

    assign o_bit = prbs31_next_bit(i_state);

endmodule

// File: rtl/prbs31_checker.sv
// Serial PRBS31 checker: self-seeds from the input, verifies, then counts errors against a local replica.
//   state     | meaning
//   ST_SEED   | shifting received bits into the replica until 31 valid bits are in
//   ST_VERIFY | comparing received bits with predictions, LOCK_BITS in a row to lock
//   ST_LOCKED | replica free-runs; mismatches are counted and watched for loss of lock
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int LOCK_BITS = 64,
    parameter int WIN_LOG2  = 7,
    parameter int LOSS_THR  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int VER_W = (LOCK_BITS > 1) ? $clog2(LOCK_BITS) : 1;
    localparam int TAL_W = $clog2(LOSS_THR + 1);

    localparam logic [4:0]       SEED_LAST = 5'(PRBS31_LEN - 1);
    localparam logic [VER_W-1:0] VER_LAST  = VER_W'(LOCK_BITS - 1);
    localparam logic [TAL_W-1:0] TAL_LOSS  = TAL_W'(LOSS_THR);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                  r_state;
    logic [PRBS31_LEN-1:0]   r_shift;
    logic [4:0]              r_seed_cnt;
    logic [VER_W-1:0]        r_ver_cnt;
    logic [WIN_LOG2-1:0]     r_win_cnt;
    logic [TAL_W-1:0]        r_tally;
    logic                    r_err_pulse;
    logic [CNT_W-1:0]        r_err_count;
    logic [CNT_W-1:0]        r_bit_count;

    logic                    w_pred;
    logic                    w_mismatch;
    logic                    w_shift_in;
    logic [PRBS31_LEN-1:0]   w_shift_nxt;
    logic [TAL_W-1:0]        w_tally_inc;
    logic                    w_is_locked;
    logic                    w_loss;

    prbs31_next u_next (
        .i_state (r_shift),
        .o_bit   (w_pred)
    );

    assign w_is_locked = (r_state == ST_LOCKED);
    assign w_mismatch  = bit_in ^ w_pred;
    // Once locked the replica free-runs, so a corrupted input bit cannot multiply into later errors.
    assign w_shift_in  = w_is_locked ? w_pred : bit_in;
    assign w_shift_nxt = {r_shift[PRBS31_LEN-2:0], w_shift_in};
    assign w_tally_inc = r_tally + TAL_W'(w_mismatch);
    assign w_loss      = w_is_locked && en && w_mismatch && (w_tally_inc == TAL_LOSS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_SEED;
            r_shift     <= '0;
            r_seed_cnt  <= '0;
            r_ver_cnt   <= '0;
            r_win_cnt   <= '0;
            r_tally     <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (en) begin
                r_shift <= w_shift_nxt;
                case (r_state)
                    ST_SEED: begin
                        if (r_seed_cnt == SEED_LAST) begin
                            r_seed_cnt <= '0;
                            // All-zero is a fixed point of the LFSR; keep seeding instead.
                            if (w_shift_nxt != '0) begin
                                r_state   <= ST_VERIFY;
                                r_ver_cnt <= '0;
                            end
                        end else begin
                            r_seed_cnt <= r_seed_cnt + 5'd1;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_mismatch) begin
                            r_state    <= ST_SEED;
                            r_seed_cnt <= '0;
                        end else if (r_ver_cnt == VER_LAST) begin
                            r_state   <= ST_LOCKED;
                            r_win_cnt <= '0;
                            r_tally   <= '0;
                        end else begin
                            r_ver_cnt <= r_ver_cnt + VER_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        r_err_pulse <= w_mismatch;
                        if (w_loss) begin
                            r_state    <= ST_SEED;
                            r_seed_cnt <= '0;
                            r_win_cnt  <= '0;
                            r_tally    <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
                            if (r_win_cnt == '1) begin
                                r_tally <= '0;
                            end else begin
                                r_tally <= w_tally_inc;
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_SEED;
                        r_seed_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
            r_bit_count <= '0;
        end else if (clear) begin
            r_err_count <= '0;
            r_bit_count <= '0;
        end else if (en && w_is_locked) begin
            if (r_bit_count != CNT_MAX) begin
                r_bit_count <= r_bit_count + CNT_W'(1);
            end
            if (w_mismatch && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign locked    = w_is_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
